instr_fetch_unit: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 53 +++++
 rtl/instr_fetch_unit_pc_reg.sv | 39 +++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: instruction word, MIPS opcodes and the
// fetch unit's state encoding (exported so benches can probe the FSM).
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 6;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [OP_W-1:0] {
        RTYPE  = 6'h00,
        REGIMM = 6'h01,
        J      = 6'h02,
        JAL    = 6'h03,
        BEQ    = 6'h04,
        BNE    = 6'h05,
        BLEZ   = 6'h06,
        BGTZ   = 6'h07,
        ADDI   = 6'h08,
        ADDIU  = 6'h09,
        SLTI   = 6'h0a,
        SLTIU  = 6'h0b,
        ANDI   = 6'h0c,
        ORI    = 6'h0d,
        XORI   = 6'h0e,
        LUI    = 6'h0f,
        LW     = 6'h23,
        LBU    = 6'h24,
        LHU    = 6'h25,
        SB     = 6'h28,
        SH     = 6'h29,
        SW     = 6'h2b,
        LL     = 6'h30,
        SC     = 6'h38,
        HALT   = 6'h3f
    } opcode_t;

    typedef enum logic [1:0] {
        START  = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    function automatic opcode_t word_opcode(input word_t w);
        return opcode_t'(w[WORD_W-1:WORD_W-OP_W]);
    endfunction

    function automatic logic is_halt(input word_t w);
        return word_opcode(w) == HALT;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register: loads a new value on request, always storing a
// word-aligned address, and provides the sequential successor PC+4.
module instr_fetch_unit_pc_reg #(
    parameter int unsigned         ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]   PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next_seq
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Both redirect targets and PC+4 pass through the mask, so pc_q stays aligned.
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_pc & ALIGN_MASK;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q <= PC_INIT;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc          = pc_q;
    assign pc_next_seq = pc_q + ADDR_W'(4);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues imem reads, holds each fetched
// word until the decoder accepts it, applies redirects and stops on HALT.
module instr_fetch_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  word_t             imemload,
    output logic              iREN,
    output logic [ADDR_W-1:0] imemaddr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output word_t             instruction,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    // Handshake: a word transfers to the decoder on any cycle where
    // instr_valid & instr_ready are both high; instr_valid never drops and
    // instruction never changes while waiting, except when a redirect
    // discards the held word. instr_ready alone has no effect.

    fetch_state_t      state_q, state_d;
    word_t             instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [31:0]       count_q, count_d;

    logic              pc_load_en;
    logic [ADDR_W-1:0] pc_load_val;
    logic [ADDR_W-1:0] pc_cur;
    logic [ADDR_W-1:0] pc_seq;
    logic              accept;

    instr_fetch_unit_pc_reg #(
        .ADDR_W  (ADDR_W),
        .PC_INIT (PC_INIT)
    ) u_pc_reg (
        .CLK         (CLK),
        .nRST        (nRST),
        .load_en     (pc_load_en),
        .load_pc     (pc_load_val),
        .pc          (pc_cur),
        .pc_next_seq (pc_seq)
    );

    assign accept = (state_q == HOLD) && valid_q && instr_ready;

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        count_d     = count_q;
        pc_load_en  = 1'b0;
        pc_load_val = pc_seq;

        unique case (state_q)
            START: begin
                state_d = FETCH;
            end
            FETCH: begin
                // A redirect in the same cycle as ihit means the returned word
                // belongs to the wrong path, so it is dropped.
                if (redirect_en) begin
                    pc_load_en  = 1'b1;
                    pc_load_val = redirect_pc;
                end else if (ihit) begin
                    instr_d = imemload;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    count_d     = count_q + 32'd1;
                    valid_d     = 1'b0;
                    pc_load_en  = 1'b1;
                    pc_load_val = redirect_en ? redirect_pc : pc_seq;
                    state_d     = is_halt(instr_q) ? HALTED : FETCH;
                end else if (redirect_en) begin
                    valid_d     = 1'b0;
                    pc_load_en  = 1'b1;
                    pc_load_val = redirect_pc;
                    state_d     = FETCH;
                end
            end
            HALTED: begin
                valid_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
                state_d = START;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= START;
            instr_q <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign iREN        = (state_q == FETCH);
    assign imemaddr    = pc_cur;
    assign instr_valid = valid_q;
    assign instruction = instr_q;
    assign pc_plus4    = pc_seq;
    assign halted      = (state_q == HALTED);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit against a behavioural
// model of the fetch/hold/redirect/halt rules.
module tb_instr_fetch_unit;
  import cpu_types_pkg::*;

  // clock / reset
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic        ihit = 1'b0;
  word_t       imemload = '0;
  logic        iREN;
  logic [31:0] imemaddr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  word_t       instruction;
  logic [31:0] pc_plus4;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halted;
  logic [31:0] fetch_count;

  instr_fetch_unit #(.ADDR_W(32), .PC_INIT(32'h0000_0000)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .imemload    (imemload),
    .iREN        (iREN),
    .imemaddr    (imemaddr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .pc_plus4    (pc_plus4),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  fetch_state_t m_st;
  logic [31:0]  m_pc;
  logic [31:0]  m_instr;
  logic [31:0]  m_cnt;
  logic         m_valid;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = START; m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_edge(input logic h, input word_t w, input logic rdy,
                            input logic ren, input logic [31:0] rpc);
    logic [31:0] tgt;
    tgt = {rpc[31:2], 2'b00};
    case (m_st)
      START: m_st = FETCH;
      FETCH: begin
        if (ren) m_pc = tgt;
        else if (h) begin m_instr = w; m_valid = 1'b1; m_st = HOLD; end
      end
      HOLD: begin
        if (rdy) begin
          m_cnt++;
          m_valid = 1'b0;
          m_pc = ren ? tgt : m_pc + 32'd4;
          m_st = (m_instr[31:26] == 6'h3f) ? HALTED : FETCH;
        end else if (ren) begin
          m_valid = 1'b0; m_pc = tgt; m_st = FETCH;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".iREN"},   32'(iREN),        32'(m_st == FETCH));
    check_eq({tag, ".addr"},   imemaddr,         m_pc);
    check_eq({tag, ".valid"},  32'(instr_valid), 32'(m_valid));
    check_eq({tag, ".instr"},  instruction,      m_instr);
    check_eq({tag, ".pc4"},    pc_plus4,         m_pc + 32'd4);
    check_eq({tag, ".halted"}, 32'(halted),      32'(m_st == HALTED));
    check_eq({tag, ".count"},  fetch_count,      m_cnt);
    check_eq({tag, ".state"},  32'(dut.state_q), 32'(m_st));
  endtask

  // driver: apply inputs, clock once, update model, check
  task automatic step(input logic h, input word_t w, input logic rdy,
                      input logic ren, input logic [31:0] rpc, input string tag);
    ihit = h; imemload = w; instr_ready = rdy; redirect_en = ren; redirect_pc = rpc;
    @(posedge CLK);
    model_edge(h, w, rdy, ren, rpc);
    #1;
    check_outputs(tag);
  endtask

  function automatic word_t rand_word();
    word_t w;
    w = $urandom;
    if (w[31:26] == 6'h3f) w[31] = 1'b0;
    return w;
  endfunction

  task automatic to_fetch();
    for (int i = 0; i < 4; i++) begin
      if (m_st == FETCH) break;
      step(1'b0, '0, 1'b1, 1'b0, '0, "to_fetch");
    end
    check_eq("to_fetch.iREN", 32'(iREN), 32'd1);
  endtask

  logic [31:0] sv_pc, sv_cnt;

  initial begin
    // reset state
    model_reset();
    #12;
    check_outputs("reset");
    @(posedge CLK); #1;
    nRST = 1'b1;
    check_eq("pre_rise.iREN", 32'(iREN), 32'd0);

    // streaming: ihit and ready always high
    step(1'b1, rand_word(), 1'b1, 1'b0, '0, "stream");
    check_eq("iren_rise", 32'(iREN), 32'd1);
    check_eq("first_addr", imemaddr, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, rand_word(), 1'b1, 1'b0, '0, "stream");
    check_eq("stream.count", fetch_count, 32'd4);
    check_eq("stream.addr", imemaddr, 32'h10);

    // backpressure
    to_fetch();
    step(1'b1, 32'h2001_0005, 1'b0, 1'b0, '0, "bp_load");
    sv_pc = imemaddr; sv_cnt = m_cnt;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b0, '0, "bp_hold");
      check_eq("bp.instr", instruction, 32'h2001_0005);
      check_eq("bp.iREN", 32'(iREN), 32'd0);
      check_eq("bp.valid", 32'(instr_valid), 32'd1);
      check_eq("bp.pc", imemaddr, sv_pc);
    end
    step(1'b0, '0, 1'b1, 1'b0, '0, "bp_accept");
    check_eq("bp.count", fetch_count, sv_cnt + 32'd1);
    check_eq("bp.next_addr", imemaddr, sv_pc + 32'd4);

    // redirect during FETCH, coincident ihit discarded
    step(1'b1, rand_word(), 1'b0, 1'b1, 32'h0000_0103, "redir_fetch");
    check_eq("redir_fetch.addr", imemaddr, 32'h100);
    check_eq("redir_fetch.valid", 32'(instr_valid), 32'd0);

    // accept with jump in the same cycle
    step(1'b1, rand_word(), 1'b0, 1'b0, '0, "jmp_load");
    sv_cnt = m_cnt;
    step(1'b0, '0, 1'b1, 1'b1, 32'h0000_0040, "jmp_accept");
    check_eq("jmp.count", fetch_count, sv_cnt + 32'd1);
    check_eq("jmp.addr", imemaddr, 32'h40);
    step(1'b1, 32'h0000_0000, 1'b0, 1'b0, '0, "jmp_nop");
    check_eq("jmp.pc4", pc_plus4, 32'h44);
    check_eq("jmp.nop_valid", 32'(instr_valid), 32'd1);

    // PC wrap at the top of the address space
    step(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFE, "wrap_redir");
    check_eq("wrap.addr", imemaddr, 32'hFFFF_FFFC);
    step(1'b1, rand_word(), 1'b0, 1'b0, '0, "wrap_load");
    check_eq("wrap.pc4", pc_plus4, 32'h0);
    step(1'b0, '0, 1'b1, 1'b0, '0, "wrap_accept");
    check_eq("wrap.next_addr", imemaddr, 32'h0);

    // randomized traffic (no HALT words)
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), $urandom, "rand");
    end

    // asynchronous reset while holding a word
    to_fetch();
    step(1'b1, rand_word(), 1'b0, 1'b0, '0, "rst_load");
    check_eq("rst_load.valid", 32'(instr_valid), 32'd1);
    #3;
    nRST = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge CLK); #1;
    check_outputs("rst_held");
    nRST = 1'b1;
    step(1'b1, rand_word(), 1'b1, 1'b0, '0, "rst_release");
    check_eq("rst_release.addr", imemaddr, 32'h0);
    check_eq("rst_release.iREN", 32'(iREN), 32'd1);

    // HALT accepted together with a redirect: halted wins
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, "halt_load");
    sv_cnt = m_cnt;
    step(1'b0, '0, 1'b1, 1'b1, 32'h0000_0080, "halt_accept");
    check_eq("halt.halted", 32'(halted), 32'd1);
    check_eq("halt.count", fetch_count, sv_cnt + 32'd1);
    for (int i = 0; i < 12; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom, "halt_stay");
      check_eq("halt_stay.iREN", 32'(iREN), 32'd0);
      check_eq("halt_stay.halted", 32'(halted), 32'd1);
      check_eq("halt_stay.valid", 32'(instr_valid), 32'd0);
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
